// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning path.
//   btn_state_e             : per-channel debounce FSM state encoding
//   BTN_UP/BTN_DOWN/BTN_CLR : channel roles that drive the press counter
//   DEBOUNCE_CYCLES_DEFAULT : 10 ms of stability at 50 MHz
package btn_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } btn_state_e;

  localparam int unsigned BTN_UP   = 0;
  localparam int unsigned BTN_DOWN = 1;
  localparam int unsigned BTN_CLR  = 2;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with stability counter and,
// when built with AUTOREPEAT_EN defined, an auto-repeat timer for held buttons.
// Ports:
//   clk_50m   : system clock
//   rst_n     : asynchronous active-low reset
//   i_btn     : raw button level, asynchronous to clk_50m
//   i_bypass  : 1 = accept every change of the synchronised level immediately
//   o_level   : debounced level
//   o_press   : one-cycle pulse on an accepted rise (and on each repeat)
//   o_release : one-cycle pulse on an accepted fall
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic i_btn,
  input  logic i_bypass,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_meta, r_sync;
  btn_state_e       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic             w_done;
  logic             r_press, r_release, w_press_d, w_release_d;
  logic             w_rep_fire;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
    end
  end

  // The sample that enters a WAIT state is the first stable one, so the
  // incremented count reaching DEBOUNCE_CYCLES-1 means DEBOUNCE_CYCLES samples.
  assign w_cnt_inc = r_cnt + CNT_ONE;
  assign w_done    = (w_cnt_inc == CNT_LAST);

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_press_d   = 1'b0;
    w_release_d = 1'b0;
    unique case (r_state)
      S_LOW: begin
        if (r_sync) begin
          w_cnt_d = '0;
          if (i_bypass) begin
            w_state_d = S_HIGH;
            w_press_d = 1'b1;
          end else begin
            w_state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (!r_sync) begin
          w_state_d = S_LOW;
          w_cnt_d   = '0;
        end else if (i_bypass || w_done) begin
          w_state_d = S_HIGH;
          w_cnt_d   = '0;
          w_press_d = 1'b1;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      S_HIGH: begin
        if (!r_sync) begin
          w_cnt_d = '0;
          if (i_bypass) begin
            w_state_d   = S_LOW;
            w_release_d = 1'b1;
          end else begin
            w_state_d = S_WAIT_LOW;
          end
        end
      end
      S_WAIT_LOW: begin
        if (r_sync) begin
          w_state_d = S_HIGH;
          w_cnt_d   = '0;
        end else if (i_bypass || w_done) begin
          w_state_d   = S_LOW;
          w_cnt_d     = '0;
          w_release_d = 1'b1;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      default: begin
        w_state_d = S_LOW;
        w_cnt_d   = '0;
      end
    endcase
  end

`ifdef AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE         = REP_W'(1);

  logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_d;
  logic             r_rep_first, w_rep_first_d;

  // Timer only runs while the channel sits in S_HIGH; any other cycle
  // (including re-entry from S_WAIT_LOW) restarts the initial delay.
  always_comb begin
    w_rep_cnt_d   = '0;
    w_rep_first_d = 1'b1;
    w_rep_fire    = 1'b0;
    if (REPEAT_EN && (r_state == S_HIGH) && (w_state_d == S_HIGH)) begin
      if (r_rep_cnt == (r_rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
        w_rep_fire    = 1'b1;
        w_rep_first_d = 1'b0;
      end else begin
        w_rep_cnt_d   = r_rep_cnt + REP_ONE;
        w_rep_first_d = r_rep_first;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else begin
      r_rep_cnt   <= w_rep_cnt_d;
      r_rep_first <= w_rep_first_d;
    end
  end
`else
  logic [31:0] w_unused_rep_cfg;
  assign w_unused_rep_cfg = REPEAT_DELAY ^ REPEAT_PERIOD ^ {31'd0, REPEAT_EN};
  assign w_rep_fire       = 1'b0;
`endif

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_LOW;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_press   <= w_press_d | w_rep_fire;
      r_release <= w_release_d;
    end
  end

  assign o_level   = (r_state == S_HIGH) || (r_state == S_WAIT_LOW);
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/btn_conditioner.sv
// Button input conditioning: per-channel synchronise + debounce with clean levels and
// press/release pulses, plus the up/down/clear press counter shown on the hex display.
// Optional build macro: AUTOREPEAT_EN enables auto-repeat presses on the up/down buttons.
// Ports:
//   clk_50m       : 50 MHz system clock
//   rst_n         : asynchronous active-low reset
//   btn_i         : raw button levels, active high, asynchronous
//   bypass_i      : 1 = skip debounce, use synchronised level directly
//   btn_level_o   : debounced levels
//   btn_press_o   : one-cycle pulse per accepted rise
//   btn_release_o : one-cycle pulse per accepted fall
//   counter_o     : press counter (btn[0] up, btn[1] down, btn[2] clear)
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_i,
  input  logic             bypass_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic [CNT_W-1:0] counter_o
);

  logic [CNT_W-1:0] r_counter;
  logic             w_up, w_down, w_clr;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      ((g == BTN_UP) || (g == BTN_DOWN))
    ) u_ch (
      .clk_50m  (clk_50m),
      .rst_n    (rst_n),
      .i_btn    (btn_i[g]),
      .i_bypass (bypass_i),
      .o_level  (btn_level_o[g]),
      .o_press  (btn_press_o[g]),
      .o_release(btn_release_o[g])
    );
  end

  assign w_up   = btn_press_o[BTN_UP];
  assign w_down = btn_press_o[BTN_DOWN];
  assign w_clr  = btn_press_o[BTN_CLR];

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_counter <= '0;
    end else if (w_clr) begin
      r_counter <= '0;
    end else if (w_up && w_down) begin
      r_counter <= r_counter;
    end else if (w_up) begin
      r_counter <= r_counter + CNT_W'(1);
    end else if (w_down) begin
      r_counter <= r_counter - CNT_W'(1);
    end
  end

  assign counter_o = r_counter;

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  localparam int unsigned N_BTN = 5;
  localparam int unsigned DEB   = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned RD    = 10;
  localparam int unsigned RP    = 3;

  logic             clk_50m = 1'b0;
  logic             rst_n   = 1'b0;
  logic [N_BTN-1:0] btn_i   = '0;
  logic             bypass_i = 1'b0;
  logic [N_BTN-1:0] btn_level_o, btn_press_o, btn_release_o;
  logic [CNT_W-1:0] counter_o;

  always #10 clk_50m = ~clk_50m;

  btn_conditioner #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CNT_W),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .btn_i        (btn_i),
    .bypass_i     (bypass_i),
    .btn_level_o  (btn_level_o),
    .btn_press_o  (btn_press_o),
    .btn_release_o(btn_release_o),
    .counter_o    (counter_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a level flips once the pin, seen two sample edges late, has
  // disagreed with it for DEB consecutive edges (or at once in bypass mode).
  logic [N_BTN-1:0] m_level, m_press, m_release;
  logic [CNT_W-1:0] m_cnt;
  int               m_run  [N_BTN];
  int               m_hold [N_BTN];
  logic [N_BTN-1:0] m_pin_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
    m_cnt     = '0;
    for (int i = 0; i < N_BTN; i++) begin
      m_run[i]  = 0;
      m_hold[i] = 0;
    end
    m_pin_q.delete();
    m_pin_q.push_back('0);
    m_pin_q.push_back('0);
  endtask

  task automatic model_edge(input logic [N_BTN-1:0] pins, input logic bp);
    logic [N_BTN-1:0] s, np, nr;
    logic was_level;
    int   was_run;
    m_pin_q.push_back(pins);
    s = m_pin_q.pop_front();
    if (m_press[2])                   m_cnt = '0;
    else if (m_press[0] && m_press[1]) m_cnt = m_cnt;
    else if (m_press[0])               m_cnt = m_cnt + 8'd1;
    else if (m_press[1])               m_cnt = m_cnt - 8'd1;
    np = '0;
    nr = '0;
    for (int i = 0; i < N_BTN; i++) begin
      was_level = m_level[i];
      was_run   = m_run[i];
      if (s[i] != m_level[i]) begin
        m_run[i]++;
        if (bp || m_run[i] >= int'(DEB)) begin
          m_level[i] = s[i];
          m_run[i]   = 0;
          if (s[i]) np[i] = 1'b1;
          else      nr[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
`ifdef AUTOREPEAT_EN
      if (i < 2) begin
        if (was_level && m_level[i] && s[i] && was_run == 0) begin
          m_hold[i]++;
          if (m_hold[i] == int'(RD) ||
              (m_hold[i] > int'(RD) && (m_hold[i] - int'(RD)) % int'(RP) == 0))
            np[i] = 1'b1;
        end else begin
          m_hold[i] = 0;
        end
      end
`endif
    end
    m_press   = np;
    m_release = nr;
  endtask

  // One clock: model follows the posedge, outputs compared at the negedge.
  task automatic tick();
    @(posedge clk_50m);
    if (rst_n) model_edge(btn_i, bypass_i);
    @(negedge clk_50m);
    check("level", btn_level_o, m_level);
    check("press", btn_press_o, m_press);
    check("release", btn_release_o, m_release);
    check("counter", counter_o, m_cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_i = '0;
    bypass_i = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic press_btn(input int idx);
    btn_i[idx] = 1'b1;
    repeat (8) tick();
    btn_i[idx] = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    logic [N_BTN-1:0] seen;
    int hit;
    int offs[$];
    int exp_off[4];

    model_reset();
    @(negedge clk_50m);
    check("rst_level", btn_level_o, 0);
    check("rst_press", btn_press_o, 0);
    check("rst_release", btn_release_o, 0);
    check("rst_counter", counter_o, 0);
    tick();
    rst_n = 1'b1;

    // Clean press: accepted 2+DEB edges after the pin change
    btn_i[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 6) check("t1_early_level", btn_level_o[0], 0);
      if (k == 6) begin
        check("t1_level", btn_level_o[0], 1);
        check("t1_press", btn_press_o[0], 1);
      end
      if (k == 7) begin
        check("t1_press_done", btn_press_o[0], 0);
        check("t1_counter", counter_o, 1);
      end
    end
    btn_i[0] = 1'b0;
    repeat (10) tick();

    // Bounce with 2-cycle glitches is rejected
    seen = '0;
    for (int k = 0; k < 18; k++) begin
      btn_i[1] = (k < 8) ? ((k % 4) < 2) : 1'b0;
      tick();
      seen = seen | btn_press_o | btn_release_o;
    end
    check("t2_no_pulse", seen, 0);
    check("t2_counter", counter_o, 1);

    // Wrap and clear
    do_reset();
    press_btn(1);
    check("t3_wrap_down", counter_o, 8'hFF);
    press_btn(0);
    press_btn(0);
    check("t3_wrap_up", counter_o, 8'h01);
    press_btn(2);
    check("t3_clear", counter_o, 8'h00);

    // Simultaneous up/down in bypass mode
    bypass_i = 1'b1;
    btn_i[1:0] = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2) check("t4_no_early", btn_press_o[1:0], 0);
      if (k == 3) check("t4_both_press", btn_press_o[1:0], 2'b11);
      if (k == 4) check("t4_counter_held", counter_o, 0);
    end
    btn_i[1:0] = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) check("t4_both_release", btn_release_o[1:0], 2'b11);
    end
    bypass_i = 1'b0;
    repeat (4) tick();

    // Reset mid-debounce restarts the full delay
    btn_i[0] = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_rst_level", btn_level_o, 0);
    check("t5_rst_press", btn_press_o, 0);
    check("t5_rst_release", btn_release_o, 0);
    check("t5_rst_counter", counter_o, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    hit = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (btn_press_o[0] && hit == 0) hit = k;
    end
    check("t5_restart_latency", hit, 6);
    btn_i[0] = 1'b0;
    repeat (10) tick();

    // Held button: auto-repeat schedule, or a single press without the feature
    do_reset();
    btn_i[0] = 1'b1;
    repeat (6) tick();
    check("t6_accept", btn_press_o[0], 1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_press_o[0]) offs.push_back(k);
    end
`ifdef AUTOREPEAT_EN
    exp_off = '{10, 13, 16, 19};
    check("t6_repeat_count", offs.size(), 4);
    for (int i = 0; i < 4; i++)
      check("t6_repeat_at", (i < offs.size()) ? offs[i] : -1, exp_off[i]);
    check("t6_counter", counter_o, 5);
`else
    exp_off = '{0, 0, 0, 0};
    check("t6_no_repeat", offs.size(), exp_off[0]);
    check("t6_counter", counter_o, 1);
`endif
    btn_i[0] = 1'b0;
    repeat (10) tick();

    // Random pin activity with occasional bypass flips and resets
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      for (int b = 0; b < N_BTN; b++)
        if ($urandom_range(0, 7) == 0) btn_i[b] = ~btn_i[b];
      if ($urandom_range(0, 299) == 0) bypass_i = ~bypass_i;
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Input-side counterpart of the hex display path. It takes raw push-button levels from the board and performs these steps:
- synchronises each button to clk_50m;
- debounces each button;
- produces clean levels plus one-cycle press and release pulses.

It also maintains the 8-bit up/down counter whose value is shown on hex0/hex1. It sits between the board button pins and the hub/display logic.

Parameters:
N_BTN, 5, number of button channels (minimum 3)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); minimum 2
CNT_W, 8, width of counter_o
REPEAT_DELAY, 25000000, cycles a held button must stay pressed before the first auto-repeat pulse (used only with AUTOREPEAT_EN)
REPEAT_PERIOD, 5000000, cycles between later auto-repeat pulses (used only with AUTOREPEAT_EN)

Ports:
clk_50m  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
btn_i  in  N_BTN  raw button levels, active high, asynchronous to clk_50m
bypass_i  in  1  1 = skip debounce; the synchronised level is used directly (board switch sw[10])
btn_level_o  out  N_BTN  debounced level per button
btn_press_o  out  N_BTN  one-cycle pulse on each accepted 0->1 transition
btn_release_o  out  N_BTN  one-cycle pulse on each accepted 1->0 transition
counter_o  out  CNT_W  press counter: btn[0] increments, btn[1] decrements, btn[2] clears

Behaviour:
Clock and reset:
- One clock, clk_50m. Reset is asynchronous and active-low (rst_n).
- On reset, all outputs are 0: btn_level_o, btn_press_o, btn_release_o and counter_o.
- On reset, all synchroniser flops, debounce counters and FSMs clear; every FSM goes to S_LOW.

Synchroniser:
- 2-flop synchroniser per channel; sync = second flop.
- Reset mid-operation discards any in-progress debounce; no pulse is emitted when reset is released.

Per-channel FSM, states S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW:
- S_LOW: if sync=1, clear the counter and go to S_WAIT_HIGH.
- S_WAIT_HIGH:
  - if sync=0, return to S_LOW (bounce rejected, no pulse);
  - otherwise increment the counter;
  - when counter = DEBOUNCE_CYCLES-1, go to S_HIGH, set level=1 and pulse press for 1 cycle.
- S_HIGH and S_WAIT_LOW mirror these rules with the polarity reversed and pulse release.
- Latency from a clean pin edge to the level/pulse is 2 + DEBOUNCE_CYCLES cycles.
- The debounce counter width is clog2(DEBOUNCE_CYCLES). It never wraps, because it is cleared on every state entry.

Bypass:
- bypass_i=1: the FSM moves S_LOW<->S_HIGH on any change of sync, in the cycle after the change, and emits the pulses.
- Latency with bypass is 3 cycles.
- If bypass_i toggles while a channel is in a WAIT state, the channel is resolved on the next cycle using the new mode.

Pulse guarantees:
- Press and release are never asserted in the same cycle for one channel.
- A press is always followed by a release before the next press.

Counter, updated on the cycle after the pulses:
- Priority: press[2] clears to 0.
- Else press[0] and press[1] together leave the count unchanged.
- Else press[0] adds 1, wrapping 2^CNT_W-1 -> 0.
- Else press[1] subtracts 1, wrapping 0 -> 2^CNT_W-1.
- Channels 3..N_BTN-1 produce levels and pulses only.

Optional Feature:
AUTOREPEAT_EN
- Defined, with btn[0] or btn[1] in S_HIGH:
  - the channel emits an extra press pulse REPEAT_DELAY cycles after entering S_HIGH, then every REPEAT_PERIOD cycles while it stays in S_HIGH;
  - the repeat timer clears on leaving S_HIGH and on reset;
  - the counter updates on every repeat pulse, with the same priority rules.
- Undefined: the repeat logic and the REPEAT_* parameters have no effect; there is exactly one press per accepted rising edge.

Decomposition:
Shared package btn_pkg holds:
- the FSM state encoding S_LOW / S_WAIT_HIGH / S_HIGH / S_WAIT_LOW;
- BTN_UP=0, BTN_DOWN=1, BTN_CLR=2;
- the default DEBOUNCE_CYCLES.

Natural sub-module btn_debounce_ch, one channel: synchroniser, FSM, debounce counter and optional repeat timer. The top instantiates it N_BTN times through a generate loop and contains the counter logic.

Test Plan:
1. Clean press: DEBOUNCE_CYCLES=4, bypass_i=0, btn_i[0] 0->1 and held.
   - btn_level_o[0]=1 and a press pulse exactly 6 cycles after the edge.
   - counter_o goes 0->1 one cycle later.
2. Bounce: btn_i[1] toggled 1,0,1,0 with 2-cycle glitches, then held low. No pulse on any output, and counter_o unchanged.
3. Wrap and clear:
   - from reset, press btn[1] once -> counter_o=8'hFF;
   - press btn[0] twice -> 8'h01;
   - press btn[2] -> 8'h00.
4. Simultaneous and bypass:
   - bypass_i=1, btn[0] and btn[1] rising in the same cycle -> both press bits high on the same cycle, counter_o unchanged;
   - a release then gives release pulses 3 cycles after the edge.
5. Reset mid-debounce: assert rst_n=0 while btn[0] is in S_WAIT_HIGH, then release rst_n with the button still held.
   - All outputs are 0 during reset.
   - After reset release, the full 2+DEBOUNCE_CYCLES delay restarts before the press pulse.
6. Auto-repeat (AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=3): hold btn[0] for 20 cycles after it is accepted.
   - Press pulses occur at +0, +10, +13, +16 and +19.
   - counter_o = 5.
